dlfloat_operand_loader: RTL and testbench

DLFLOAT_OPERAND_LOADER -- requirements
Module: dlfloat_operand_loader

---
 rtl/dlfloat_pkg.sv | 28 ++
 rtl/dlfloat_idle_timer.sv | 42 ++++
 rtl/dlfloat_operand_loader.sv | 140 ++++++++++++++
 tb/tb_dlfloat_operand_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions for the operand loader: field widths, frame
// geometry, loader state encoding and a small field-decoding helper.
package dlfloat_pkg;

   // DLFloat16 layout: 1 sign bit, 6 exponent bits, 9 mantissa bits
   localparam int unsigned EXP_W = 6;
   localparam int unsigned MAN_W = 9;
   localparam int unsigned DLF_W = 1 + EXP_W + MAN_W;

   // One frame carries an A/B operand pair as big-endian bytes
   localparam int unsigned FRAME_BYTES = 4;
   localparam int unsigned BYTE_W      = (2 * DLF_W) / FRAME_BYTES;

   // Loader states: one per expected byte, then the hand-off to the MAC
   typedef enum logic [2:0] {
      A_HI  = 3'd0,
      A_LO  = 3'd1,
      B_HI  = 3'd2,
      B_LO  = 3'd3,
      ISSUE = 3'd4
   } load_state_e;

   // True when the exponent field is all ones (Inf/NaN class encoding)
   function automatic logic dlf_exp_all_ones(input logic [DLF_W-1:0] value);
      return &value[MAN_W +: EXP_W];
   endfunction

endpackage

// File: rtl/dlfloat_idle_timer.sv
// Idle-cycle counter for the operand loader. Counts consecutive ticks and
// flags expiry combinationally on the tick that reaches TIMEOUT_CYC, then
// restarts from zero so a single expiry produces a single event.
module dlfloat_idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYC);

   logic [15:0] count_q;
   logic [15:0] count_d;
   logic [16:0] count_inc;

   assign count_inc = {1'b0, count_q} + 17'd1;
   assign expired   = tick && (count_inc == LIMIT);

   // Next count: clearing and expiry both restart the count, a tick advances it
   always_comb begin
      count_d = count_q;
      if (clear || expired) begin
         count_d = 16'd0;
      end else if (tick) begin
         count_d = count_inc[15:0];
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// DLFloat16 operand loader: assembles 4-byte big-endian frames from the 8-bit
// pad bus into an A/B operand pair and hands it to the MAC with valid/ready.
// A start-of-frame byte seen mid-frame restarts the frame; a partial frame
// left idle for TIMEOUT_CYC cycles is dropped with an err_timeout pulse.
// Optional feature macro: DLFLOAT_SPECIAL_CHECK_EN adds output op_special,
// flagging a pair where either operand has an all-ones exponent.
module dlfloat_operand_loader
   import dlfloat_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [7:0]  pair_cnt,
   output logic        err_timeout
`ifdef DLFLOAT_SPECIAL_CHECK_EN
   ,
   output logic        op_special
`endif
);

   load_state_e      state_q;
   load_state_e      state_d;
   logic [DLF_W-1:0] op_a_q;
   logic [DLF_W-1:0] op_a_d;
   logic [DLF_W-1:0] op_b_q;
   logic [DLF_W-1:0] op_b_d;
   logic [7:0]       pair_cnt_q;
   logic [7:0]       pair_cnt_d;
   logic             err_timeout_q;
   logic             err_timeout_d;

   logic accept;
   logic in_partial;
   logic idle_tick;
   logic idle_clear;
   logic timeout_hit;

   assign in_ready    = (state_q != ISSUE);
   assign accept      = in_valid && in_ready;
   assign in_partial  = (state_q == A_LO) || (state_q == B_HI) || (state_q == B_LO);
   assign idle_tick   = in_partial && !accept;
   assign idle_clear  = !in_partial || accept;

   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_valid    = (state_q == ISSUE);
   assign pair_cnt    = pair_cnt_q;
   assign err_timeout = err_timeout_q;

`ifdef DLFLOAT_SPECIAL_CHECK_EN
   assign op_special = op_valid && (dlf_exp_all_ones(op_a_q) || dlf_exp_all_ones(op_b_q));
`endif

   dlfloat_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (idle_clear),
      .tick    (idle_tick),
      .expired (timeout_hit)
   );

   // Frame assembly, resync on start-of-frame, timeout drop and MAC hand-off
   always_comb begin
      state_d       = state_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      pair_cnt_d    = pair_cnt_q;
      err_timeout_d = 1'b0;

      unique case (state_q)
         A_HI: begin
            if (accept) begin
               op_a_d[DLF_W-1 -: BYTE_W] = in_byte;
               state_d                   = A_LO;
            end
         end

         A_LO, B_HI, B_LO: begin
            if (accept) begin
               if (in_sof) begin
                  op_a_d[DLF_W-1 -: BYTE_W] = in_byte;
                  state_d                   = A_LO;
               end else if (state_q == A_LO) begin
                  op_a_d[BYTE_W-1:0] = in_byte;
                  state_d            = B_HI;
               end else if (state_q == B_HI) begin
                  op_b_d[DLF_W-1 -: BYTE_W] = in_byte;
                  state_d                   = B_LO;
               end else begin
                  op_b_d[BYTE_W-1:0] = in_byte;
                  state_d            = ISSUE;
               end
            end else if (timeout_hit) begin
               err_timeout_d = 1'b1;
               state_d       = A_HI;
            end
         end

         ISSUE: begin
            if (op_ready) begin
               pair_cnt_d = pair_cnt_q + 8'd1;
               state_d    = A_HI;
            end
         end

         default: begin
            state_d = A_HI;
         end
      endcase
   end

   // State, operand, counter and error-pulse registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= A_HI;
         op_a_q        <= '0;
         op_b_q        <= '0;
         pair_cnt_q    <= 8'd0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         pair_cnt_q    <= pair_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Testbench for dlfloat_operand_loader: table of frames with hand-computed
// operands and hold times, plus directed sequences for resync, timeout,
// pair counter wrap and reset during hand-off.
module tb_dlfloat_operand_loader;

   localparam int unsigned TO_CYC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_valid;
   logic        op_ready;
   logic [7:0]  pair_cnt;
   logic        err_timeout;
`ifdef DLFLOAT_SPECIAL_CHECK_EN
   logic        op_special;
`endif

   int         compared   = 0;
   int         mismatched = 0;
   logic [7:0] exp_pairs;

   typedef struct {
      logic [31:0] frame;
      logic        sof0;
      int          hold;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs[5];

   dlfloat_operand_loader #(
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_byte     (in_byte),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .pair_cnt    (pair_cnt),
      .err_timeout (err_timeout)
`ifdef DLFLOAT_SPECIAL_CHECK_EN
      ,
      .op_special  (op_special)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Time limit so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual timeout reached, required finish before limit");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic driveByte(input logic [7:0] b, input logic sof);
      @(negedge clk);
      checkOutput("in_ready_before_byte", {31'd0, in_ready}, 32'd1);
      in_byte  = b;
      in_sof   = sof;
      in_valid = 1'b1;
   endtask

   task automatic sendFrame(input logic [31:0] f, input logic sof0);
      driveByte(f[31:24], sof0);
      driveByte(f[23:16], 1'b0);
      driveByte(f[15:8], 1'b0);
      driveByte(f[7:0], 1'b0);
   endtask

   task automatic finishFrame(input logic [15:0] ea, input logic [15:0] eb, input int hold);
      for (int i = 0; i <= hold; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
         checkOutput("op_valid_issue", {31'd0, op_valid}, 32'd1);
         checkOutput("op_a_issue", {16'd0, op_a}, {16'd0, ea});
         checkOutput("op_b_issue", {16'd0, op_b}, {16'd0, eb});
         checkOutput("in_ready_issue", {31'd0, in_ready}, 32'd0);
`ifdef DLFLOAT_SPECIAL_CHECK_EN
         checkOutput("op_special_model", {31'd0, op_special},
                     {31'd0, (&ea[14:9]) || (&eb[14:9])});
`endif
         op_ready = (i == hold);
      end
      @(negedge clk);
      op_ready  = 1'b0;
      exp_pairs = exp_pairs + 8'd1;
      checkOutput("op_valid_after", {31'd0, op_valid}, 32'd0);
      checkOutput("in_ready_after", {31'd0, in_ready}, 32'd1);
      checkOutput("pair_cnt", {24'd0, pair_cnt}, {24'd0, exp_pairs});
   endtask

   task automatic applyStimulus();
      logic [31:0] f;
      // Reset state
      in_byte  = 8'h00;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      op_ready = 1'b0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_op_valid", {31'd0, op_valid}, 32'd0);
      checkOutput("rst_op_a", {16'd0, op_a}, 32'd0);
      checkOutput("rst_op_b", {16'd0, op_b}, 32'd0);
      checkOutput("rst_pair_cnt", {24'd0, pair_cnt}, 32'd0);
      checkOutput("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
      rst       = 1'b0;
      exp_pairs = 8'd0;
      @(negedge clk);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         sendFrame(vecs[v].frame, vecs[v].sof0);
         finishFrame(vecs[v].ea, vecs[v].eb, vecs[v].hold);
      end

      // Resync: two bytes then a fresh start-of-frame
      driveByte(8'hAA, 1'b1);
      driveByte(8'hBB, 1'b0);
      sendFrame(32'h41223344, 1'b1);
      finishFrame(16'h4122, 16'h3344, 0);

      // Resync from B_LO
      driveByte(8'h11, 1'b1);
      driveByte(8'h22, 1'b0);
      driveByte(8'h33, 1'b0);
      sendFrame(32'h55667788, 1'b1);
      finishFrame(16'h5566, 16'h7788, 1);

      // Timeout: one byte then TO_CYC idle cycles
      driveByte(8'h99, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      checkOutput("err_timeout_idle1", {31'd0, err_timeout}, 32'd0);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         checkOutput("err_timeout_early", {31'd0, err_timeout}, 32'd0);
      end
      @(negedge clk);
      checkOutput("err_timeout_pulse", {31'd0, err_timeout}, 32'd1);
      checkOutput("in_ready_after_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      checkOutput("err_timeout_single", {31'd0, err_timeout}, 32'd0);
      sendFrame(32'h01020304, 1'b0);
      finishFrame(16'h0102, 16'h0304, 0);

`ifdef DLFLOAT_SPECIAL_CHECK_EN
      // Special exponent flag
      sendFrame(32'h7E001234, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("op_special_set", {31'd0, op_special}, 32'd1);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready  = 1'b0;
      exp_pairs = exp_pairs + 8'd1;
      sendFrame(32'h3E003F00, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("op_special_clear", {31'd0, op_special}, 32'd0);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready  = 1'b0;
      exp_pairs = exp_pairs + 8'd1;
`endif

      // Reset pulse while idle, then 256 pairs wrap the counter
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      exp_pairs = 8'd0;
      checkOutput("pair_cnt_cleared", {24'd0, pair_cnt}, 32'd0);
      for (int i = 0; i < 256; i++) begin
         f = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'h3C};
         sendFrame(f, 1'b1);
         finishFrame(f[31:16], f[15:0], 0);
      end
      checkOutput("pair_cnt_wrap", {24'd0, pair_cnt}, 32'd0);

      // Reset while a pair waits in ISSUE drops it
      sendFrame(32'hCAFE0123, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("op_valid_pre_reset", {31'd0, op_valid}, 32'd1);
      rst      = 1'b1;
      op_ready = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      op_ready = 1'b0;
      checkOutput("op_valid_post_reset", {31'd0, op_valid}, 32'd0);
      checkOutput("pair_cnt_post_reset", {24'd0, pair_cnt}, 32'd0);
      checkOutput("in_ready_post_reset", {31'd0, in_ready}, 32'd1);
      checkOutput("op_a_post_reset", {16'd0, op_a}, 32'd0);
      exp_pairs = 8'd0;
      sendFrame(32'h3C003D00, 1'b1);
      finishFrame(16'h3C00, 16'h3D00, 0);
   endtask

   // Main test sequence
   initial begin
      vecs[0] = '{frame: 32'h3E003F00, sof0: 1'b1, hold: 0, ea: 16'h3E00, eb: 16'h3F00};
      vecs[1] = '{frame: 32'h12345678, sof0: 1'b1, hold: 5, ea: 16'h1234, eb: 16'h5678};
      vecs[2] = '{frame: 32'hFFFF0001, sof0: 1'b1, hold: 2, ea: 16'hFFFF, eb: 16'h0001};
      vecs[3] = '{frame: 32'hA5C30000, sof0: 1'b0, hold: 1, ea: 16'hA5C3, eb: 16'h0000};
      vecs[4] = '{frame: 32'h7E0080FF, sof0: 1'b1, hold: 0, ea: 16'h7E00, eb: 16'h80FF};
      applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
